// File: rtl/rgp16_pkg.sv
// rtl/rgp16_pkg.sv - shared loader constants: FSM encoding, long-instruction flag bit, default address limit
package rgp16_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_OP_HI  = 3'd1;
  localparam logic [2:0] ST_OP_LO  = 3'd2;
  localparam logic [2:0] ST_IMM_HI = 3'd3;
  localparam logic [2:0] ST_IMM_LO = 3'd4;
  localparam logic [2:0] ST_FIN    = 3'd5;

  localparam int          LONG_INSTR_BIT   = 15;
  localparam logic [15:0] DEFAULT_MAX_ADDR = 16'h03FF;

endpackage

// File: rtl/byte_pack.sv
// rtl/byte_pack.sv - holds the high byte of a word and presents {high, current} as the assembled word
module byte_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hi_we,
  input  logic [7:0]  byte_in,
  output logic [15:0] word
);

  logic [7:0] hi_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_byte <= 8'h00;
    end else if (hi_we) begin
      hi_byte <= byte_in;
    end
  end

  assign word = {hi_byte, byte_in};

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader writing 16-bit words into instruction memory
// Optional csum output enabled by LOADER_CHECKSUM_EN.
module prog_loader
  import rgp16_pkg::*;
#(
  parameter logic [15:0] MAX_ADDR = DEFAULT_MAX_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] instr_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0] csum
`endif
);

  logic [2:0]  state;
  logic [16:0] addr;
  logic [15:0] word;
  logic        accept;
  logic        hi_phase;
  logic        addr_ovf;

  assign byte_ready = (state == ST_OP_HI) || (state == ST_OP_LO) ||
                      (state == ST_IMM_HI) || (state == ST_IMM_LO);
  assign busy       = (state != ST_IDLE);
  assign accept     = byte_valid && byte_ready;
  assign hi_phase   = (state == ST_OP_HI) || (state == ST_IMM_HI);
  // 17-bit address so the limit check can never be defeated by a wrap past 16'hFFFF
  assign addr_ovf   = addr > {1'b0, MAX_ADDR};

  byte_pack u_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .hi_we   (accept && hi_phase),
    .byte_in (byte_in),
    .word    (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      addr        <= 17'd0;
      mem_addr    <= 16'h0000;
      mem_data    <= 16'h0000;
      mem_we      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      instr_count <= 16'h0000;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_OP_HI;
            addr        <= {1'b0, base_addr};
            err         <= 1'b0;
            instr_count <= 16'h0000;
          end
        end
        ST_OP_HI, ST_IMM_HI: begin
          if (accept) begin
            if (byte_last) begin
              err   <= 1'b1;
              state <= ST_FIN;
            end else begin
              state <= (state == ST_OP_HI) ? ST_OP_LO : ST_IMM_LO;
            end
          end
        end
        ST_OP_LO, ST_IMM_LO: begin
          if (accept) begin
            if (addr_ovf) begin
              err   <= 1'b1;
              state <= ST_FIN;
            end else begin
              mem_we   <= 1'b1;
              mem_addr <= addr[15:0];
              mem_data <= word;
              addr     <= addr + 17'd1;
              if ((state == ST_OP_LO) && word[LONG_INSTR_BIT]) begin
                if (byte_last) begin
                  err   <= 1'b1;
                  state <= ST_FIN;
                end else begin
                  state <= ST_IMM_HI;
                end
              end else begin
                instr_count <= instr_count + 16'd1;
                state       <= byte_last ? ST_FIN : ST_OP_HI;
              end
            end
          end
        end
        ST_FIN: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= 16'h0000;
    end else if ((state == ST_IDLE) && start) begin
      csum <= 16'h0000;
    end else if (accept && !hi_phase && !addr_ovf) begin
      csum <= csum + word;
    end
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed bench with a word-level loader model and per-cycle output checks
module tb_prog_loader;

  localparam logic [15:0] MAX = 16'h03FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'h0000;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_last = 1'b0;
  logic        byte_ready, mem_we, busy, done, err;
  logic [15:0] mem_addr, mem_data, instr_count;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] csum;
`endif

  int total = 0;
  int bad = 0;

  logic [31:0] exp_q[$];
  logic        exp_fw, exp_err;
  logic [15:0] exp_cnt, exp_csum;
  bit          load_active = 0;
  bit          done_seen = 0;
  bit          prev_we = 0;
  int          age = 9;
  int          writes_seen = 0;

  prog_loader #(.MAX_ADDR(MAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_last   (byte_last),
    .byte_ready  (byte_ready),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_we      (mem_we),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .instr_count (instr_count)
`ifdef LOADER_CHECKSUM_EN
    ,
    .csum        (csum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Per-cycle checker: writes must match the model queue, done must close the load.
  always @(negedge clk) begin
    if (!rst_n) begin
      age     = 9;
      prev_we = 0;
    end else begin
      logic [31:0] e;
      if (age < 9) age++;
      if (mem_we) begin
        chk("we_busy", {31'd0, busy}, 32'd1);
        chk("we_latency", age, 32'd1);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {16'd0, mem_addr}, {16'd0, e[31:16]});
          chk("wr_data", {16'd0, mem_data}, {16'd0, e[15:0]});
        end
        writes_seen++;
      end
      if (!busy) chk("ready_idle", {31'd0, byte_ready}, 32'd0);
      if (done) begin
        if (!load_active) begin
          fail_now("unexpected_done");
        end else begin
          chk("done_after_we", {31'd0, prev_we}, {31'd0, exp_fw});
          chk("done_latency", age, 32'd2);
          chk("done_err", {31'd0, err}, {31'd0, exp_err});
          chk("done_cnt", {16'd0, instr_count}, {16'd0, exp_cnt});
          chk("done_left", exp_q.size(), 32'd0);
`ifdef LOADER_CHECKSUM_EN
          chk("done_csum", {16'd0, csum}, {16'd0, exp_csum});
`endif
          load_active = 0;
          done_seen   = 1;
        end
      end
      prev_we = mem_we;
      if (byte_valid && byte_ready) age = 0;
    end
  end

  function automatic logic [7:0] nth(input logic [63:0] bs, input int k);
    return bs[63 - 8*k -: 8];
  endfunction

  // Word-level model: walk the stream two bytes at a time applying the loader rules.
  task automatic model(input logic [15:0] base, input int n, input logic [63:0] bs);
    logic [16:0] a;
    logic [15:0] w;
    bit          long_pending, last;
    a = {1'b0, base};
    long_pending = 0;
    exp_q.delete();
    exp_fw = 0; exp_err = 0; exp_cnt = 0; exp_csum = 0;
    for (int k = 0; k < n; k += 2) begin
      if (k == n - 1) begin
        exp_err = 1; exp_fw = 0;
        break;
      end
      w    = {nth(bs, k), nth(bs, k + 1)};
      last = (k + 1 == n - 1);
      if (a > {1'b0, MAX}) begin
        exp_err = 1; exp_fw = 0;
        break;
      end
      exp_q.push_back({a[15:0], w});
      exp_csum = exp_csum + w;
      a = a + 17'd1;
      exp_fw = 1;
      if (!long_pending && w[15]) begin
        if (last) begin
          exp_err = 1;
          break;
        end
        long_pending = 1;
      end else begin
        exp_cnt = exp_cnt + 16'd1;
        long_pending = 0;
        if (last) break;
      end
    end
  endtask

  task automatic run_load(input logic [15:0] base, input int n, input logic [63:0] bs,
                          input int nw, input int cnt, input bit e, input int rs, input int gap);
    bit accepted;
    model(base, n, bs);
    writes_seen = 0;
    done_seen   = 0;
    @(posedge clk); #1;
    start = 1; base_addr = base; load_active = 1;
    @(posedge clk); #1;
    start = 0; base_addr = 16'hBEEF;
    chk("busy_start", {31'd0, busy}, 32'd1);
    for (int k = 0; k < n; k++) begin
      byte_in = nth(bs, k); byte_valid = 1; byte_last = (k == n - 1);
      if (k == rs) begin start = 1; base_addr = 16'h0050; end
      accepted = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (byte_ready) begin accepted = 1; break; end
        if (!busy) break;
      end
      if (!accepted) begin
        if (busy) begin total++; bad++; $display("FAIL byte_timeout: got no ready expected ready"); end
        break;
      end
      @(posedge clk); #1;
      start = 0; base_addr = 16'hBEEF; byte_valid = 0; byte_last = 0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    start = 0; byte_valid = 0; byte_last = 0;
    for (int c = 0; c < 20 && !done_seen; c++) @(negedge clk);
    if (!done_seen) begin total++; bad++; $display("FAIL done_timeout: got no done expected done"); end
    chk("nw_lit", writes_seen, nw);
    chk("cnt_lit", {16'd0, instr_count}, cnt);
    chk("err_lit", {31'd0, err}, {31'd0, e});
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_cnt", {16'd0, instr_count}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1;

    run_load(16'h0010, 2, 64'h1234_0000_0000_0000, 1, 1, 0, -1, 0);
    run_load(16'h0000, 6, 64'h8001_ABCD_0005_0000, 3, 2, 0, -1, 0);
`ifdef LOADER_CHECKSUM_EN
    chk("csum_lit", {16'd0, csum}, 32'h2BD3);
`endif
    run_load(16'h0000, 2, 64'h8001_0000_0000_0000, 1, 0, 1, -1, 0);
    run_load(16'h03FF, 4, 64'h0001_0002_0000_0000, 1, 1, 1, -1, 0);
    run_load(16'h0000, 1, 64'h1200_0000_0000_0000, 0, 0, 1, -1, 0);
    run_load(16'h0020, 4, 64'h1234_5678_0000_0000, 2, 2, 0, 1, 0);
    run_load(16'h03FE, 8, 64'hC000_1122_3344_5566, 2, 1, 1, -1, 0);
    run_load(16'h0100, 8, 64'h0102_8304_0506_0708, 4, 3, 0, -1, 1);
    run_load(16'h0500, 2, 64'h1234_0000_0000_0000, 0, 0, 1, -1, 0);

    // Bytes offered while idle must be refused.
    byte_in = 8'hAA; byte_valid = 1; byte_last = 1;
    repeat (4) begin @(posedge clk); #1; end
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_ready", {31'd0, byte_ready}, 32'd0);
    byte_valid = 0; byte_last = 0;

    // Mid-load reset after bytes 12 34 56.
    exp_q.delete();
    exp_q.push_back({16'h0040, 16'h1234});
    load_active = 1;
    @(posedge clk); #1;
    start = 1; base_addr = 16'h0040;
    @(posedge clk); #1;
    start = 0;
    byte_valid = 1; byte_in = 8'h12; @(posedge clk); #1;
    byte_in = 8'h34; @(posedge clk); #1;
    byte_in = 8'h56; @(posedge clk); #1;
    byte_valid = 0;
    chk("pre_rst_cnt", {16'd0, instr_count}, 32'd1);
    chk("pre_rst_addr", {16'd0, mem_addr}, 32'h0040);
    #1;
    load_active = 0;
    rst_n = 0;
    #1;
    chk("arst_addr", {16'd0, mem_addr}, 32'd0);
    chk("arst_data", {16'd0, mem_data}, 32'd0);
    chk("arst_cnt", {16'd0, instr_count}, 32'd0);
    chk("arst_we", {31'd0, mem_we}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_ready", {31'd0, byte_ready}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
    chk("arst_csum", {16'd0, csum}, 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (5) @(negedge clk);
    chk("post_rst_left", exp_q.size(), 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: MAX_ADDR, default 16'h03FF, highest writable instruction-memory word address.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  one-cycle pulse that begins a load at base_addr; ignored while busy=1.
REQ-005 Port: base_addr  input  16  first word address; sampled on the accepted start.
REQ-006 Port: byte_in  input  8  stream byte; high byte of each 16-bit word arrives first.
REQ-007 Port: byte_valid  input  1  byte_in valid.
REQ-008 Port: byte_last  input  1  qualifies the final byte of the stream; meaningful only with byte_valid.
REQ-009 Port: byte_ready  output  1  loader accepts a byte; a transfer occurs when byte_valid and byte_ready are both 1.
REQ-010 Port: mem_addr  output  16  instruction-memory write address.
REQ-011 Port: mem_data  output  16  instruction-memory write data.
REQ-012 Port: mem_we  output  1  one-cycle write strobe.
REQ-013 Port: busy  output  1  a load is in progress.
REQ-014 Port: done  output  1  one-cycle pulse at the end of a load, normal or errored.
REQ-015 Port: err  output  1  sticky error flag; cleared by the next accepted start.
REQ-016 Port: instr_count  output  16  number of complete instructions written in the current load.

Function
REQ-017 The FSM SHALL have these states: IDLE, OP_HI, OP_LO, IMM_HI, IMM_LO, FIN.
- IDLE to OP_HI on an accepted start.
- OP_HI to OP_LO and IMM_HI to IMM_LO on an accepted byte.
REQ-018 byte_ready SHALL be 1 only in OP_HI, OP_LO, IMM_HI and IMM_LO.
REQ-019 On an accepted byte in OP_LO or IMM_LO, the loader SHALL form the word {high byte, low byte}.
- It SHALL drive mem_data with that word and mem_addr with the current address.
- It SHALL assert mem_we for exactly the next cycle (one cycle latency).
- It SHALL then increment the address by 1.
REQ-020 In OP_LO, word bit 15 = 1 (long instruction) SHALL transition to IMM_HI; bit 15 = 0 SHALL transition to OP_HI and increment instr_count.
REQ-021 In IMM_LO, the loader SHALL transition to OP_HI and increment instr_count.
REQ-022 byte_last accepted in OP_LO with bit 15 = 0, or in IMM_LO, SHALL write the word and then enter FIN.
REQ-023 FIN SHALL assert done for one cycle (the cycle after the final mem_we) and return to IDLE.
REQ-024 byte_last accepted in OP_HI or IMM_HI (odd byte count) SHALL discard the byte, set err, and go to FIN with no write.
REQ-025 byte_last accepted in OP_LO with bit 15 = 1 (missing immediate) SHALL write the word, set err, leave instr_count unchanged, and go to FIN.
REQ-026 A write whose address exceeds MAX_ADDR SHALL be suppressed (mem_we stays 0); the loader SHALL set err and go to FIN. No wrap-around is allowed.
REQ-027 instr_count SHALL wrap modulo 2^16; this is not an error.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 start SHALL clear err and instr_count in the same edge that leaves IDLE.

Reset
REQ-030 rst_n = 0 SHALL immediately force:
- state to IDLE;
- mem_addr, mem_data and instr_count to 16'h0000;
- mem_we, busy, done, err and byte_ready to 0.
REQ-031 Reset asserted mid-load SHALL abandon the load without any further write or done pulse.

Configuration
REQ-032 With LOADER_CHECKSUM_EN defined, the module SHALL add output csum (16 bits).
- csum is the modulo-2^16 sum of every word actually written (suppressed writes excluded).
- It is cleared by start and by reset, and updates in the mem_we cycle.
REQ-033 Without LOADER_CHECKSUM_EN, the csum port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-034 The shared package rgp16_pkg SHALL hold the FSM state encoding, the constant LONG_INSTR_BIT = 15, and the default MAX_ADDR.
REQ-035 Byte-to-word assembly (high-byte register plus word output) SHALL be the sub-module byte_pack; the FSM, address counter and checks stay in prog_loader.

Verification
REQ-036 start with base_addr = 16'h0010, then bytes 12 34 (last) -> one mem_we: addr 0010, data 1234; done one cycle later; instr_count = 1; err = 0.
REQ-037 Bytes 80 01 AB CD 00 05 (last), base 0 -> writes 0:8001, 1:ABCD, 2:0005; instr_count = 2; with LOADER_CHECKSUM_EN, csum = 16'h2BD3.
REQ-038 Bytes 80 01 (last) -> write 0:8001; err = 1; instr_count = 0; done pulses.
REQ-039 base_addr = 16'h03FF, bytes 00 01 00 02 (last) -> write 03FF:0001 only; second write suppressed; err = 1; done pulses.
REQ-040 Bytes 12 (last) -> no write; err = 1. Reset asserted after byte 56 of a load -> all outputs 0 immediately; no done pulse.
REQ-041 start while busy -> no restart and base_addr not resampled; byte_valid in IDLE -> byte_ready = 0 and no write.
